// File: rtl/lcd_timing_pkg.sv
// Purpose: shared timing constants, FSM encoding and coordinate width for the RGB LCD driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: 800x480 and 480x272 default panel timings, lcd_state_t, coord_t.
package lcd_timing_pkg;

   localparam int COORD_W = 11;
   typedef logic [COORD_W-1:0] coord_t;

   // Power-up sequencer states; ST_RUN is terminal until the next rst_n assertion.
   typedef enum logic [1:0] {
      ST_PANEL_RST  = 2'd0,
      ST_PANEL_WAIT = 2'd1,
      ST_RUN        = 2'd2
   } lcd_state_t;

   // 800x480 panel
   localparam coord_t T800_H_SYNC  = 11'd128;
   localparam coord_t T800_H_BACK  = 11'd88;
   localparam coord_t T800_H_DISP  = 11'd800;
   localparam coord_t T800_H_FRONT = 11'd40;
   localparam coord_t T800_V_SYNC  = 11'd2;
   localparam coord_t T800_V_BACK  = 11'd33;
   localparam coord_t T800_V_DISP  = 11'd480;
   localparam coord_t T800_V_FRONT = 11'd10;

   // 480x272 panel
   localparam coord_t T480_H_SYNC  = 11'd41;
   localparam coord_t T480_H_BACK  = 11'd2;
   localparam coord_t T480_H_DISP  = 11'd480;
   localparam coord_t T480_H_FRONT = 11'd2;
   localparam coord_t T480_V_SYNC  = 11'd10;
   localparam coord_t T480_V_BACK  = 11'd2;
   localparam coord_t T480_V_DISP  = 11'd272;
   localparam coord_t T480_V_FRONT = 11'd2;

endpackage

// File: rtl/lcd_sync_counter.sv
// Purpose: modulo-N up counter with enable and a same-cycle wrap pulse.
// Latency: cnt updates one cycle after en; wrap is combinational (en && cnt==N-1).
// Backpressure: none; the counter simply holds while en is low.
// Ports: lcd_pclk/rst_n clock and async reset, en advance, cnt current value, wrap last-count pulse.
module lcd_sync_counter #(
   parameter int unsigned  W = 11,
   parameter logic [W-1:0] N = W'(2)
) (
   input  logic         lcd_pclk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(N - W'(1));

   assign wrap = en && (cnt == LAST);

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= wrap ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/lcd_driver.sv
// Purpose: RGB LCD timing generator, power-up sequencer and pixel sink.
// Latency: sync/enable/coordinate outputs decode the current counters; pixel_data passes to lcd_rgb in the same cycle.
// Backpressure: none; the source must return pixel_data one cycle after pixel_xpos.
// Ports: lcd_pclk/rst_n; pixel_data in; pixel_xpos/ypos, h_disp/v_disp, data_req, frame_start
//        toward the source; lcd_de/hs/vs/rgb/rst/bl toward the panel.
module lcd_driver
   import lcd_timing_pkg::*;
#(
   parameter coord_t      H_SYNC      = T800_H_SYNC,
   parameter coord_t      H_BACK      = T800_H_BACK,
   parameter coord_t      H_DISP      = T800_H_DISP,
   parameter coord_t      H_FRONT     = T800_H_FRONT,
   parameter coord_t      V_SYNC      = T800_V_SYNC,
   parameter coord_t      V_BACK      = T800_V_BACK,
   parameter coord_t      V_DISP      = T800_V_DISP,
   parameter coord_t      V_FRONT     = T800_V_FRONT,
   parameter logic        SYNC_POL    = 1'b0,
   parameter logic [15:0] RST_CYCLES  = 16'd50000,
   parameter logic [15:0] WAIT_CYCLES = 16'd50000
) (
   input  logic         lcd_pclk,
   input  logic         rst_n,
   input  logic [23:0]  pixel_data,
   output coord_t       pixel_xpos,
   output coord_t       pixel_ypos,
   output coord_t       h_disp,
   output coord_t       v_disp,
   output logic         data_req,
   output logic         frame_start,
   output logic         lcd_de,
   output logic         lcd_hs,
   output logic         lcd_vs,
   output logic [23:0]  lcd_rgb,
   output logic         lcd_rst,
   output logic         lcd_bl
);

   localparam int H_TOTAL = int'(H_SYNC) + int'(H_BACK) + int'(H_DISP) + int'(H_FRONT);
   localparam int V_TOTAL = int'(V_SYNC) + int'(V_BACK) + int'(V_DISP) + int'(V_FRONT);
   localparam int HA_I    = int'(H_SYNC) + int'(H_BACK);
   localparam int VA_I    = int'(V_SYNC) + int'(V_BACK);

   if (H_SYNC < 11'd1 || HA_I < 2 || V_SYNC < 11'd1 || H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_cfg
      $error("lcd_driver: illegal timing parameters");
   end

   // Window bounds; data_req opens one column early so a registered source lines up with lcd_de.
   localparam coord_t HA      = coord_t'(HA_I);
   localparam coord_t HA_END  = coord_t'(HA_I + int'(H_DISP));
   localparam coord_t REQ_BEG = coord_t'(HA_I - 1);
   localparam coord_t REQ_END = coord_t'(HA_I + int'(H_DISP) - 1);
   localparam coord_t X_OFS   = coord_t'(HA_I - 2);
   localparam coord_t VA      = coord_t'(VA_I);
   localparam coord_t VA_END  = coord_t'(VA_I + int'(V_DISP));
   localparam coord_t Y_OFS   = coord_t'(VA_I - 1);

   lcd_state_t  state, state_nxt;
   logic [15:0] seq_cnt, seq_cnt_nxt;
   coord_t      h_cnt, v_cnt;
   logic        run, h_wrap, v_wrap, vact;

   // ---------------- power-up sequencer ----------------
   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_PANEL_RST;
         seq_cnt     <= '0;
         lcd_rst     <= 1'b0;
         lcd_bl      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_nxt;
         seq_cnt     <= seq_cnt_nxt;
         lcd_rst     <= (state_nxt != ST_PANEL_RST);
         lcd_bl      <= (state_nxt == ST_RUN);
         // Counters are at 0/0 on the first RUN cycle and right after every frame wrap.
         frame_start <= ((state_nxt == ST_RUN) && (state != ST_RUN)) || v_wrap;
      end
   end

   always_comb begin
      state_nxt   = state;
      seq_cnt_nxt = seq_cnt;
      unique case (state)
         ST_PANEL_RST: begin
            if (seq_cnt == RST_CYCLES - 16'd1) begin
               state_nxt   = ST_PANEL_WAIT;
               seq_cnt_nxt = '0;
            end else begin
               seq_cnt_nxt = seq_cnt + 16'd1;
            end
         end
         ST_PANEL_WAIT: begin
            if (seq_cnt == WAIT_CYCLES - 16'd1) begin
               state_nxt   = ST_RUN;
               seq_cnt_nxt = '0;
            end else begin
               seq_cnt_nxt = seq_cnt + 16'd1;
            end
         end
         ST_RUN: begin
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt   = ST_PANEL_RST;
            seq_cnt_nxt = '0;
         end
      endcase
   end

   assign run = (state == ST_RUN);

   // ---------------- scan counters ----------------
   lcd_sync_counter #(
      .W (COORD_W),
      .N (coord_t'(H_TOTAL))
   ) u_h_cnt (
      .lcd_pclk (lcd_pclk),
      .rst_n    (rst_n),
      .en       (run),
      .cnt      (h_cnt),
      .wrap     (h_wrap)
   );

   lcd_sync_counter #(
      .W (COORD_W),
      .N (coord_t'(V_TOTAL))
   ) u_v_cnt (
      .lcd_pclk (lcd_pclk),
      .rst_n    (rst_n),
      .en       (h_wrap),
      .cnt      (v_cnt),
      .wrap     (v_wrap)
   );

   // ---------------- output decode ----------------
   assign vact = run && (v_cnt >= VA) && (v_cnt < VA_END);

   assign lcd_hs   = (run && (h_cnt < H_SYNC)) ? SYNC_POL : ~SYNC_POL;
   assign lcd_vs   = (run && (v_cnt < V_SYNC)) ? SYNC_POL : ~SYNC_POL;
   assign data_req = vact && (h_cnt >= REQ_BEG) && (h_cnt < REQ_END);
   assign lcd_de   = vact && (h_cnt >= HA) && (h_cnt < HA_END);

   // Column numbering starts at 1 on the first data_req cycle.
   assign pixel_xpos = data_req ? coord_t'(h_cnt - X_OFS) : '0;
   // Held across the whole line, blanking included, for line-level source decisions.
   assign pixel_ypos = vact ? coord_t'(v_cnt - Y_OFS) : '0;

   assign lcd_rgb = lcd_de ? pixel_data : 24'd0;

   assign h_disp = H_DISP;
   assign v_disp = V_DISP;

endmodule

// File: tb/tb_lcd_driver.sv
`timescale 1ns/1ps
module tb_lcd_driver;

   localparam int HS = 2, HB = 3, HD = 8, HF = 2;
   localparam int VS = 1, VB = 2, VD = 4, VF = 1;
   localparam int RSTC = 4, WAITC = 6;
   localparam int HT = HS + HB + HD + HF;   // 15
   localparam int VT = VS + VB + VD + VF;   // 8
   localparam int HA = HS + HB;             // 5
   localparam int VA = VS + VB;             // 3
   localparam int PWR = RSTC + WAITC;       // 10

   logic        lcd_pclk = 1'b0;
   logic        rst_n    = 1'b0;
   logic [23:0] pixel_data;
   logic [10:0] pixel_xpos, pixel_ypos, h_disp, v_disp;
   logic        data_req, frame_start, lcd_de, lcd_hs, lcd_vs, lcd_rst, lcd_bl;
   logic [23:0] lcd_rgb;

   int checks = 0;
   int errors = 0;
   bit pat_mode = 1'b1;

   always #5 lcd_pclk = ~lcd_pclk;

   lcd_driver #(
      .H_SYNC(11'd2), .H_BACK(11'd3), .H_DISP(11'd8), .H_FRONT(11'd2),
      .V_SYNC(11'd1), .V_BACK(11'd2), .V_DISP(11'd4), .V_FRONT(11'd1),
      .SYNC_POL(1'b0), .RST_CYCLES(16'd4), .WAIT_CYCLES(16'd6)
   ) dut (
      .lcd_pclk(lcd_pclk), .rst_n(rst_n), .pixel_data(pixel_data),
      .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .h_disp(h_disp), .v_disp(v_disp),
      .data_req(data_req), .frame_start(frame_start), .lcd_de(lcd_de), .lcd_hs(lcd_hs),
      .lcd_vs(lcd_vs), .lcd_rgb(lcd_rgb), .lcd_rst(lcd_rst), .lcd_bl(lcd_bl)
   );

   // Pixel source: registered, either a column pattern or random data.
   always @(posedge lcd_pclk)
      pixel_data <= pat_mode ? {3{pixel_xpos[7:0]}} : 24'($urandom);

   typedef struct {
      int          k;
      logic        rst, bl, hs, vs, req, de, fs;
      logic [10:0] x, y;
      logic [23:0] rgb;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s @k=%0d: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   // Reference: k = clock edges since rst_n release; everything follows from cycle arithmetic.
   function automatic vec_t model(input int k, input logic [23:0] pd, input bit pat);
      vec_t e;
      int p, h, v;
      bit run, va;
      logic [7:0] c8;
      e.k   = k;
      e.rst = (k >= RSTC);
      e.bl  = (k >= PWR);
      run   = e.bl;
      p     = run ? k - PWR : 0;
      h     = p % HT;
      v     = (p / HT) % VT;
      va    = run && v >= VA && v < VA + VD;
      e.hs  = !(run && h < HS);
      e.vs  = !(run && v < VS);
      e.req = va && h >= HA - 1 && h < HA + HD - 1;
      e.de  = va && h >= HA && h < HA + HD;
      e.fs  = run && h == 0 && v == 0;
      e.x   = e.req ? 11'(h - HA + 2) : 11'd0;
      e.y   = va ? 11'(v - VA + 1) : 11'd0;
      c8    = 8'(h - HA + 1);
      e.rgb = !e.de ? 24'd0 : (pat ? {c8, c8, c8} : pd);
      return e;
   endfunction

   task automatic cmp(input string tag, input int k, input vec_t e);
      chk({tag, ".lcd_rst"},     k, 32'(lcd_rst),     32'(e.rst));
      chk({tag, ".lcd_bl"},      k, 32'(lcd_bl),      32'(e.bl));
      chk({tag, ".lcd_hs"},      k, 32'(lcd_hs),      32'(e.hs));
      chk({tag, ".lcd_vs"},      k, 32'(lcd_vs),      32'(e.vs));
      chk({tag, ".data_req"},    k, 32'(data_req),    32'(e.req));
      chk({tag, ".lcd_de"},      k, 32'(lcd_de),      32'(e.de));
      chk({tag, ".frame_start"}, k, 32'(frame_start), 32'(e.fs));
      chk({tag, ".pixel_xpos"},  k, 32'(pixel_xpos),  32'(e.x));
      chk({tag, ".pixel_ypos"},  k, 32'(pixel_ypos),  32'(e.y));
      chk({tag, ".lcd_rgb"},     k, 32'(lcd_rgb),     32'(e.rgb));
   endtask

   task automatic check_reset_state(input string tag);
      vec_t e;
      e = '{k: 0, rst: 0, bl: 0, hs: 1, vs: 1, req: 0, de: 0, fs: 0, x: 0, y: 0, rgb: 0};
      cmp(tag, -1, e);
   endtask

   task automatic release_reset();
      @(posedge lcd_pclk);
      #1 rst_n = 1'b1;
   endtask

   // Sample k = 0..last at negedges after release, comparing with the model (and the table if asked).
   task automatic run_checked(input int last, input bit use_tbl, output int fs_seen);
      int fs_prev;
      fs_prev = -1;
      fs_seen = 0;
      for (int k = 0; k <= last; k++) begin
         @(negedge lcd_pclk);
         cmp("model", k, model(k, pixel_data, pat_mode));
         if (use_tbl)
            for (int i = 0; i < 17; i++)
               if (tbl[i].k == k) cmp("table", k, tbl[i]);
         if (frame_start) begin
            if (fs_prev >= 0) chk("frame_period", k, 32'(k - fs_prev), 32'(HT * VT));
            fs_prev = k;
            fs_seen++;
         end
      end
   endtask

   initial begin
      int nfs;
      int rk;
      //              k  rst bl hs vs req de fs  x  y  rgb
      tbl[0]  = '{  0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0};
      tbl[1]  = '{  3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0};
      tbl[2]  = '{  4, 1, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0};
      tbl[3]  = '{  9, 1, 0, 1, 1, 0, 0, 0, 0, 0, 24'h0};
      tbl[4]  = '{ 10, 1, 1, 0, 0, 0, 0, 1, 0, 0, 24'h0};
      tbl[5]  = '{ 25, 1, 1, 0, 1, 0, 0, 0, 0, 0, 24'h0};
      tbl[6]  = '{ 55, 1, 1, 0, 1, 0, 0, 0, 0, 1, 24'h0};
      tbl[7]  = '{ 56, 1, 1, 0, 1, 0, 0, 0, 0, 1, 24'h0};
      tbl[8]  = '{ 57, 1, 1, 1, 1, 0, 0, 0, 0, 1, 24'h0};
      tbl[9]  = '{ 59, 1, 1, 1, 1, 1, 0, 0, 1, 1, 24'h0};
      tbl[10] = '{ 60, 1, 1, 1, 1, 1, 1, 0, 2, 1, 24'h010101};
      tbl[11] = '{ 66, 1, 1, 1, 1, 1, 1, 0, 8, 1, 24'h070707};
      tbl[12] = '{ 67, 1, 1, 1, 1, 0, 1, 0, 0, 1, 24'h080808};
      tbl[13] = '{ 68, 1, 1, 1, 1, 0, 0, 0, 0, 1, 24'h0};
      tbl[14] = '{104, 1, 1, 1, 1, 1, 0, 0, 1, 4, 24'h0};
      tbl[15] = '{119, 1, 1, 1, 1, 0, 0, 0, 0, 0, 24'h0};
      tbl[16] = '{130, 1, 1, 0, 0, 0, 0, 1, 0, 0, 24'h0};

      // Reset state and constant outputs.
      repeat (3) @(posedge lcd_pclk);
      @(negedge lcd_pclk);
      check_reset_state("reset");
      chk("h_disp", -1, 32'(h_disp), 32'(HD));
      chk("v_disp", -1, 32'(v_disp), 32'(VD));

      // Power-up, one full frame plus the next frame start, with the pattern source.
      release_reset();
      run_checked(140, 1'b1, nfs);
      chk("frame_start_count", 140, 32'(nfs), 32'd2);

      // Reset mid-frame at v_cnt=4, h_cnt=7 (k = 10 + 4*15 + 7 = 77).
      @(negedge lcd_pclk);
      rst_n = 1'b0;
      repeat (2) @(posedge lcd_pclk);
      release_reset();
      run_checked(77, 1'b0, nfs);
      chk("midframe_de_before", 77, 32'(lcd_de), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_reset_state("async_reset");
      @(negedge lcd_pclk);
      check_reset_state("held_reset");
      release_reset();
      run_checked(135, 1'b0, nfs);
      chk("restart_frame_start_count", 135, 32'(nfs), 32'd2);

      // Random pixel data and random reset points.
      pat_mode = 1'b0;
      for (int it = 0; it < 4; it++) begin
         rk = $urandom_range(250, 5);
         rst_n = 1'b0;
         repeat ($urandom_range(3, 1)) @(posedge lcd_pclk);
         release_reset();
         run_checked(rk, 1'b0, nfs);
         #1 rst_n = 1'b0;
         #1 check_reset_state("rand_async_reset");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
